pipelined_core_param: RTL and testbench



---
 rtl/pipelined_core_param.sv | 250 +++++++++++++++++++++++++
 tb/tb_pipelined_core_param.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_core_param.sv
// pipelined_core_param: parametrised 5-stage in-order core (IF, ID, EX, MEM, WB)
// with internal instruction/data memories, operand forwarding, load-use stall,
// branch-with-flush resolved in EX, HALT drain, run/freeze and a debug read port.
module pipelined_core_param #(
    parameter int DATA_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH  = 5,
    parameter int IMEM_ADDR_WIDTH = 8,
    parameter int DMEM_ADDR_WIDTH = 8,
    parameter int LED_WIDTH       = 8
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       run,
    input  logic                       imemWe,
    input  logic [IMEM_ADDR_WIDTH-1:0] imemAddr,
    input  logic [31:0]                imemData,
    input  logic [REG_ADDR_WIDTH-1:0]  dbgRegAddr,
    output logic [DATA_WIDTH-1:0]      dbgRegData,
    output logic                       halted,
    output logic [31:0]                retired,
    output logic [LED_WIDTH-1:0]       led
);

    localparam int NUM_REGS   = 1 << REG_ADDR_WIDTH;
    localparam int IMEM_DEPTH = 1 << IMEM_ADDR_WIDTH;
    localparam int DMEM_DEPTH = 1 << DMEM_ADDR_WIDTH;

    localparam logic [3:0] opAdd  = 4'd1;
    localparam logic [3:0] opSub  = 4'd2;
    localparam logic [3:0] opAnd  = 4'd3;
    localparam logic [3:0] opOr   = 4'd4;
    localparam logic [3:0] opAddi = 4'd5;
    localparam logic [3:0] opLw   = 4'd6;
    localparam logic [3:0] opSw   = 4'd7;
    localparam logic [3:0] opBeq  = 4'd8;
    localparam logic [3:0] opHalt = 4'd15;

    logic [31:0]           imem    [IMEM_DEPTH];
    logic [DATA_WIDTH-1:0] dmem    [DMEM_DEPTH];
    logic [DATA_WIDTH-1:0] regFile [NUM_REGS];

    logic [IMEM_ADDR_WIDTH-1:0] pc;

    // IF/ID
    logic                       ifIdValid;
    logic [31:0]                ifIdInstr;
    logic [IMEM_ADDR_WIDTH-1:0] ifIdPc;

    // ID/EX
    logic                       idExValid;
    logic [3:0]                 idExOp;
    logic [REG_ADDR_WIDTH-1:0]  idExRd, idExRs, idExRt;
    logic [DATA_WIDTH-1:0]      idExA, idExB, idExImm;
    logic [IMEM_ADDR_WIDTH-1:0] idExPc;

    // EX/MEM
    logic                       exMemValid, exMemRegWrite, exMemIsLoad, exMemIsStore, exMemIsHalt;
    logic [REG_ADDR_WIDTH-1:0]  exMemRd;
    logic [DATA_WIDTH-1:0]      exMemResult, exMemStoreData;

    // MEM/WB
    logic                       memWbValid, memWbRegWrite, memWbIsHalt;
    logic [REG_ADDR_WIDTH-1:0]  memWbRd;
    logic [DATA_WIDTH-1:0]      memWbData;

    // Set once HALT reaches EX; keeps the front end frozen until reset.
    logic                       haltPending;

    // Decode
    logic [3:0]                 idOp;
    logic [REG_ADDR_WIDTH-1:0]  idRd, idRs, idRt;
    logic signed [12:0]         idImmRaw;
    logic [DATA_WIDTH-1:0]      idImm, idRsVal, idRtVal;
    logic                       wbWrite;

    assign idOp     = ifIdInstr[31:28];
    assign idRd     = ifIdInstr[23 +: REG_ADDR_WIDTH];
    assign idRs     = ifIdInstr[18 +: REG_ADDR_WIDTH];
    assign idRt     = ifIdInstr[13 +: REG_ADDR_WIDTH];
    assign idImmRaw = ifIdInstr[12:0];
    assign idImm    = DATA_WIDTH'(idImmRaw);

    assign wbWrite  = run && memWbValid && memWbRegWrite && (memWbRd != '0);

    // Write-first register file: a same-cycle WB write bypasses into ID.
    assign idRsVal  = (wbWrite && memWbRd == idRs) ? memWbData : regFile[idRs];
    assign idRtVal  = (wbWrite && memWbRd == idRt) ? memWbData : regFile[idRt];

    // Execute: forwarding, ALU, branch and hazard detection
    logic                       fwdExMemA, fwdExMemB, fwdMemWbA, fwdMemWbB;
    logic [DATA_WIDTH-1:0]      fwdA, fwdB, aluResult;
    logic                       exTaken, exHalt, loadUse, frontFreeze;
    logic [IMEM_ADDR_WIDTH-1:0] branchTarget;

    assign fwdExMemA = exMemValid && exMemRegWrite && !exMemIsLoad && (exMemRd != '0) && (exMemRd == idExRs);
    assign fwdExMemB = exMemValid && exMemRegWrite && !exMemIsLoad && (exMemRd != '0) && (exMemRd == idExRt);
    assign fwdMemWbA = memWbValid && memWbRegWrite && (memWbRd != '0) && (memWbRd == idExRs);
    assign fwdMemWbB = memWbValid && memWbRegWrite && (memWbRd != '0) && (memWbRd == idExRt);

    assign fwdA = fwdExMemA ? exMemResult : (fwdMemWbA ? memWbData : idExA);
    assign fwdB = fwdExMemB ? exMemResult : (fwdMemWbB ? memWbData : idExB);

    // ALU result for the instruction currently in EX
    always_comb begin
        aluResult = '0;
        case (idExOp)
            opAdd:              aluResult = fwdA + fwdB;
            opSub:              aluResult = fwdA - fwdB;
            opAnd:              aluResult = fwdA & fwdB;
            opOr:               aluResult = fwdA | fwdB;
            opAddi, opLw, opSw: aluResult = fwdA + idExImm;
            default:            aluResult = '0;
        endcase
    end

    assign exTaken      = idExValid && (idExOp == opBeq) && (fwdA == fwdB);
    assign exHalt       = idExValid && (idExOp == opHalt);
    assign branchTarget = idExPc + IMEM_ADDR_WIDTH'(1) + idExImm[IMEM_ADDR_WIDTH-1:0];
    assign loadUse      = idExValid && (idExOp == opLw) && (idExRd != '0) && ifIdValid
                          && ((idExRd == idRs) || (idExRd == idRt));
    assign frontFreeze  = haltPending || exHalt;

    // Memory stage read
    logic [DATA_WIDTH-1:0] memReadData;
    assign memReadData = dmem[exMemResult[DMEM_ADDR_WIDTH-1:0]];

    assign dbgRegData = regFile[dbgRegAddr];
    assign led        = regFile[1][LED_WIDTH-1:0];

    // Instruction memory load port; a fetch of the same word this edge sees the old value
    always_ff @(posedge clk) begin
        if (imemWe) imem[imemAddr] <= imemData;
    end

    // Fetch: PC and IF/ID with branch redirect, halt freeze and load-use hold
    always_ff @(posedge clk) begin
        if (!resetN) begin
            pc        <= '0;
            ifIdValid <= 1'b0;
            ifIdInstr <= '0;
            ifIdPc    <= '0;
        end else if (run) begin
            if (exTaken) begin
                pc        <= branchTarget;
                ifIdValid <= 1'b0;
            end else if (frontFreeze) begin
                ifIdValid <= 1'b0;
            end else if (!loadUse) begin
                pc        <= pc + IMEM_ADDR_WIDTH'(1);
                ifIdValid <= 1'b1;
                ifIdInstr <= imem[pc];
                ifIdPc    <= pc;
            end
        end
    end

    // Decode: ID/EX, bubbled on branch flush, halt or load-use stall
    always_ff @(posedge clk) begin
        if (!resetN) begin
            idExValid <= 1'b0;
            idExOp    <= '0;
            idExRd    <= '0;
            idExRs    <= '0;
            idExRt    <= '0;
            idExA     <= '0;
            idExB     <= '0;
            idExImm   <= '0;
            idExPc    <= '0;
        end else if (run) begin
            idExValid <= ifIdValid && !(exTaken || frontFreeze || loadUse);
            idExOp    <= idOp;
            idExRd    <= idRd;
            idExRs    <= idRs;
            idExRt    <= idRt;
            idExA     <= idRsVal;
            idExB     <= idRtVal;
            idExImm   <= idImm;
            idExPc    <= ifIdPc;
        end
    end

    // Execute: EX/MEM register
    always_ff @(posedge clk) begin
        if (!resetN) begin
            exMemValid     <= 1'b0;
            exMemRegWrite  <= 1'b0;
            exMemIsLoad    <= 1'b0;
            exMemIsStore   <= 1'b0;
            exMemIsHalt    <= 1'b0;
            exMemRd        <= '0;
            exMemResult    <= '0;
            exMemStoreData <= '0;
        end else if (run) begin
            exMemValid     <= idExValid;
            exMemRegWrite  <= idExValid && (idExOp inside {opAdd, opSub, opAnd, opOr, opAddi, opLw});
            exMemIsLoad    <= idExValid && (idExOp == opLw);
            exMemIsStore   <= idExValid && (idExOp == opSw);
            exMemIsHalt    <= exHalt;
            exMemRd        <= idExRd;
            exMemResult    <= aluResult;
            exMemStoreData <= fwdB;
        end
    end

    // Data memory store on the edge that ends MEM
    always_ff @(posedge clk) begin
        if (resetN && run && exMemValid && exMemIsStore)
            dmem[exMemResult[DMEM_ADDR_WIDTH-1:0]] <= exMemStoreData;
    end

    // Memory: MEM/WB register, load data or ALU result
    always_ff @(posedge clk) begin
        if (!resetN) begin
            memWbValid    <= 1'b0;
            memWbRegWrite <= 1'b0;
            memWbIsHalt   <= 1'b0;
            memWbRd       <= '0;
            memWbData     <= '0;
        end else if (run) begin
            memWbValid    <= exMemValid;
            memWbRegWrite <= exMemRegWrite;
            memWbIsHalt   <= exMemIsHalt;
            memWbRd       <= exMemRd;
            memWbData     <= exMemIsLoad ? memReadData : exMemResult;
        end
    end

    // Write-back into the register file; r0 is never written so it reads 0
    always_ff @(posedge clk) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_REGS; i++) regFile[i] <= '0;
        end else if (wbWrite) begin
            regFile[memWbRd] <= memWbData;
        end
    end

    // Status: halt tracking and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!resetN) begin
            haltPending <= 1'b0;
            halted      <= 1'b0;
            retired     <= '0;
        end else if (run) begin
            if (exHalt)                    haltPending <= 1'b1;
            if (memWbValid && !halted)     retired     <= retired + 32'd1;
            if (memWbValid && memWbIsHalt) halted      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipelined_core_param.sv
// Bench for pipelined_core_param: ISA-level interpreter gives the architectural
// register state after every retired instruction; a per-cycle compare process
// checks led/debug port/halted against the state indexed by the DUT's retire
// count, and end-of-program checks pin cycle counts and literal results.
module tb_pipelined_core_param;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        run = 1'b0;
    logic        imemWe = 1'b0;
    logic [7:0]  imemAddr = '0;
    logic [31:0] imemData = '0;
    logic [4:0]  dbgRegAddr;
    logic [31:0] dbgRegData;
    logic        halted;
    logic [31:0] retired;
    logic [7:0]  led;

    always #5 clk = ~clk;

    pipelined_core_param #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .IMEM_ADDR_WIDTH(8),
        .DMEM_ADDR_WIDTH(8), .LED_WIDTH(8)
    ) dut (
        .clk(clk), .resetN(resetN), .run(run), .imemWe(imemWe),
        .imemAddr(imemAddr), .imemData(imemData), .dbgRegAddr(dbgRegAddr),
        .dbgRegData(dbgRegData), .halted(halted), .retired(retired), .led(led)
    );

    int errors = 0;
    int checks = 0;

    logic       chkEn = 1'b0;
    logic [4:0] cmpSel = '0;
    logic [4:0] mainSel = '0;
    assign dbgRegAddr = chkEn ? cmpSel : mainSel;

    logic [31:0] prog   [0:255];
    logic [31:0] mDmem  [0:255];
    logic [31:0] expReg [0:63][0:31];
    int expR, expS, expT;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt, input int imm);
        return {op[3:0], rd[4:0], rs[4:0], rt[4:0], imm[12:0]};
    endfunction

    // Architectural interpreter: state after each retirement, plus stall/branch counts
    task automatic runModel();
        logic [31:0] r [0:31];
        logic [31:0] ins, nxt, a, b, imm, w;
        logic [3:0]  op;
        logic [4:0]  rd, rs, rt;
        logic        wr;
        int pc, npc;
        for (int i = 0; i < 32; i++) begin
            r[i] = '0;
            expReg[0][i] = '0;
        end
        expR = 0; expS = 0; expT = 0; pc = 0;
        for (int step = 0; step < 60; step++) begin
            ins = prog[pc];
            op = ins[31:28]; rd = ins[27:23]; rs = ins[22:18]; rt = ins[17:13];
            imm = {{19{ins[12]}}, ins[12:0]};
            a = r[rs]; b = r[rt];
            npc = (pc + 1) & 255;
            wr = 1'b0; w = '0;
            case (op)
                4'd1: begin w = a + b;   wr = 1'b1; end
                4'd2: begin w = a - b;   wr = 1'b1; end
                4'd3: begin w = a & b;   wr = 1'b1; end
                4'd4: begin w = a | b;   wr = 1'b1; end
                4'd5: begin w = a + imm; wr = 1'b1; end
                4'd6: begin w = mDmem[(a + imm) & 32'hFF]; wr = 1'b1; end
                4'd7: mDmem[(a + imm) & 32'hFF] = b;
                4'd8: if (a == b) begin
                          npc = (pc + 1 + int'(imm)) & 255;
                          expT++;
                      end
                default: ;
            endcase
            if (wr && rd != 5'd0) r[rd] = w;
            if (op == 4'd6 && rd != 5'd0) begin
                nxt = prog[(pc + 1) & 255];
                if (nxt[22:18] == rd || nxt[17:13] == rd) expS++;
            end
            expR++;
            for (int i = 0; i < 32; i++) expReg[expR][i] = r[i];
            pc = npc;
            if (op == 4'd15) break;
        end
    endtask

    // Per-cycle compare against the architectural state at the DUT's retire count
    initial begin : compareProc
        int idx;
        forever begin
            @(negedge clk);
            if (chkEn) begin
                if (retired > 32'(expR)) begin
                    checks++;
                    errors++;
                    $display("FAIL trace retired: got %0d expected at most %0d", retired, expR);
                end else begin
                    idx = int'(retired);
                    check("trace led", 32'(led), 32'(expReg[idx][1][7:0]));
                    check("trace dbgReg", dbgRegData, expReg[idx][cmpSel]);
                    check("trace halted", 32'(halted), 32'(retired == 32'(expR)));
                end
                cmpSel = cmpSel + 5'd1;
            end
        end
    end

    task automatic clearProg();
        for (int i = 0; i < 256; i++) prog[i] = '0;
    endtask

    task automatic readReg(input string name, input int idx, input logic [31:0] lit);
        mainSel = 5'(idx);
        #1;
        check(name, dbgRegData, lit);
    endtask

    task automatic runTest(input string name, input int freezeAt, input int freezeRetLit,
                           input int resetAt, input int expCycLit, input int expRetLit);
        int cyc, rstAt;
        bit done;
        @(negedge clk);
        resetN = 1'b0;
        run = 1'b1;
        for (int i = 0; i < 16; i++) begin
            imemWe = 1'b1;
            imemAddr = 8'(i);
            imemData = prog[i];
            @(negedge clk);
        end
        imemWe = 1'b0;
        @(negedge clk);
        runModel();
        chkEn = 1'b1;
        resetN = 1'b1;
        cyc = 0; done = 0; rstAt = resetAt;
        while (!done && cyc < 300) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (halted) begin
                done = 1;
            end else if (cyc == freezeAt) begin
                run = 1'b0;
                repeat (10) begin
                    @(posedge clk);
                    cyc++;
                end
                @(negedge clk);
                check({name, " frozen retired"}, retired, 32'(freezeRetLit));
                check({name, " frozen halted"}, 32'(halted), 32'd0);
                run = 1'b1;
            end else if (cyc == rstAt) begin
                resetN = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check({name, " midreset retired"}, retired, 32'd0);
                check({name, " midreset halted"}, 32'(halted), 32'd0);
                check({name, " midreset led"}, 32'(led), 32'd0);
                resetN = 1'b1;
                cyc = 0;
                rstAt = -1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got halted=%0d expected 1 within 300 cycles", name, halted);
        end
        chkEn = 1'b0;
        check({name, " cycles vs model"}, 32'(cyc),
              32'(expR + 4 + expS + 2 * expT + ((freezeAt > 0) ? 10 : 0)));
        check({name, " cycles"}, 32'(cyc), 32'(expCycLit));
        check({name, " retired vs model"}, retired, 32'(expR));
        check({name, " retired"}, retired, 32'(expRetLit));
        check({name, " halted"}, 32'(halted), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mDmem[i] = '0;
        // Clear instruction memory while held in reset
        resetN = 1'b0;
        imemWe = 1'b1;
        for (int i = 0; i < 256; i++) begin
            imemAddr = 8'(i);
            imemData = '0;
            @(negedge clk);
        end
        imemWe = 1'b0;
        @(negedge clk);
        check("reset retired", retired, 32'd0);
        check("reset halted", 32'(halted), 32'd0);
        check("reset led", 32'(led), 32'd0);

        // Basic program
        clearProg();
        prog[0] = enc(5, 1, 0, 0, 5);
        prog[1] = enc(5, 2, 0, 0, 7);
        prog[2] = enc(1, 3, 1, 2, 0);
        prog[3] = enc(15, 0, 0, 0, 0);
        runTest("basic", 0, 0, -1, 8, 4);
        readReg("basic r3", 3, 32'd12);
        check("basic led", 32'(led), 32'd5);

        // Back-to-back dependencies through forwarding
        clearProg();
        prog[0] = enc(5, 1, 0, 0, 1);
        prog[1] = enc(1, 1, 1, 1, 0);
        prog[2] = enc(1, 1, 1, 1, 0);
        prog[3] = enc(1, 1, 1, 1, 0);
        prog[4] = enc(15, 0, 0, 0, 0);
        runTest("fwd", 0, 0, -1, 9, 5);
        readReg("fwd r1", 1, 32'd8);

        // Store, load, load-use stall
        clearProg();
        prog[0] = enc(5, 2, 0, 0, 9);
        prog[1] = enc(7, 0, 0, 2, 3);
        prog[2] = enc(6, 4, 0, 0, 3);
        prog[3] = enc(1, 5, 4, 4, 0);
        prog[4] = enc(15, 0, 0, 0, 0);
        runTest("loaduse", 0, 0, -1, 10, 5);
        readReg("loaduse r4", 4, 32'd9);
        readReg("loaduse r5", 5, 32'd18);

        // Taken branch skipping two instructions, then a not-taken branch
        clearProg();
        prog[0] = enc(5, 1, 0, 0, 3);
        prog[1] = enc(5, 2, 0, 0, 4);
        prog[2] = enc(8, 0, 0, 0, 2);
        prog[3] = enc(5, 6, 0, 0, 1);
        prog[4] = enc(5, 6, 0, 0, 2);
        prog[5] = enc(8, 0, 1, 2, 5);
        prog[6] = enc(1, 7, 1, 2, 0);
        prog[7] = enc(15, 0, 0, 0, 0);
        runTest("branch", 0, 0, -1, 12, 6);
        readReg("branch r6", 6, 32'd0);
        readReg("branch r7", 7, 32'd7);

        // Same store/load program with a 10-cycle freeze after edge 6
        clearProg();
        prog[0] = enc(5, 2, 0, 0, 9);
        prog[1] = enc(7, 0, 0, 2, 3);
        prog[2] = enc(6, 4, 0, 0, 3);
        prog[3] = enc(1, 5, 4, 4, 0);
        prog[4] = enc(15, 0, 0, 0, 0);
        runTest("freeze", 6, 2, -1, 20, 5);
        readReg("freeze r5", 5, 32'd18);

        // Reset mid-program, restart, all-ones immediate
        clearProg();
        prog[0] = enc(5, 1, 0, 0, 5);
        prog[1] = enc(5, 2, 0, 0, 7);
        prog[2] = enc(1, 3, 1, 2, 0);
        prog[3] = enc(5, 7, 0, 0, 13'h1FFF);
        prog[4] = enc(15, 0, 0, 0, 0);
        runTest("restart", 0, 0, 6, 9, 5);
        readReg("restart r3", 3, 32'd12);
        readReg("restart r7", 7, 32'hFFFF_FFFF);
        check("restart led", 32'(led), 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
